pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter WIDTH, default 128: payload width in bits (decoded fields plus operand data).
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream stage presents a payload.
REQ-006 in_ready  output  1  buffer accepts a payload this cycle; driven directly from a flop.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 flush  input  1  discard all held payloads (branch taken or exception).
REQ-009 out_valid  output  1  out_data holds a live payload.
REQ-010 out_ready  input  1  downstream stage consumes the payload this cycle.
REQ-011 out_data  output  WIDTH  downstream payload; driven directly from a flop.
REQ-012 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating.

Function
REQ-013 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
REQ-014 Storage: main register (drives out_data) plus one skid register; occupancy 0, 1 or 2.
REQ-015 States: EMPTY (occ 0), HALF (occ 1, main live), FULL (occ 2, main and skid live).
REQ-016 EMPTY: transfer in -> HALF, in_data into main; otherwise stay.
REQ-017 HALF: in only -> FULL, in_data into skid; out only -> EMPTY; in and out together -> HALF, in_data into main; neither -> stay.
REQ-018 FULL: out -> HALF, skid moves into main; no out -> stay; in_ready=0 so no transfer in.
REQ-019 in_ready = 1 in EMPTY and HALF, 0 in FULL, evaluated from registered state only; no combinational path from out_ready to in_ready.
REQ-020 out_valid = 1 in HALF and FULL.
REQ-021 Latency: payload accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when buffer was EMPTY, or HALF with simultaneous out.
REQ-022 Ordering: payloads leave in acceptance order; no loss, no duplication.
REQ-023 Every WIDTH bit of in_data is captured; no field may be dropped or double-assigned.
REQ-024 out_data holds its value while out_valid=1 and out_ready=0.
REQ-025 flush=1: next state EMPTY regardless of in_valid, out_ready and current state; payload offered that cycle is discarded; out_data is not cleared.
REQ-026 flush has priority over all transfers in the same cycle; in_ready still reflects pre-flush state that cycle.
REQ-027 stall_cnt increments by 1 per stall cycle, holds at 2^CNT_W-1, and is unaffected by flush.
REQ-028 in_valid with in_ready=0 has no effect; upstream holds in_data.

Reset
REQ-029 reset=1 at posedge: state EMPTY, main and skid registers zero, stall_cnt zero.
REQ-030 Outputs after reset: out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
REQ-031 reset has priority over flush and all transfers; reset mid-FULL discards both payloads.

Structure
REQ-032 Shared pipeline package holds the state enumeration (EMPTY, HALF, FULL) and the default WIDTH constant.
REQ-033 Single module, no sub-modules; payload field packing is done by the instantiating stage.

Verification
REQ-034 Reset, then in_valid=1 with in_data=0xA5, out_ready=1 -> cycle+1: out_valid=1, out_data=0xA5; in_ready stays 1.
REQ-035 Stream 0x1,0x2,0x3 with out_ready=0 -> after 2 accepts in_ready=0, 0x3 held upstream; raise out_ready -> outputs 0x1,0x2,0x3 in order, no gaps after the first.
REQ-036 FULL, out_ready=0 for 5 cycles -> stall_cnt=5; CNT_W=3 with 10 stall cycles -> stall_cnt=7.
REQ-037 FULL with flush=1, in_valid=1, in_data=0x9 -> next cycle out_valid=0, in_ready=1; 0x9 never emerges.
REQ-038 HALF with in and out in the same cycle for 100 cycles (incrementing data) -> every value emerges exactly once, 1-cycle latency, in_ready never drops.
REQ-039 reset asserted in FULL together with flush and in_valid -> next cycle out_valid=0, out_data=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer_pkg
// Shared pipeline definitions: the default payload width and the occupancy
// state encoding used by pipeline stage buffers.
// -----------------------------------------------------------------------------
package pipe_stage_buffer_pkg;

  // Default payload width (decoded fields plus operand data).
  localparam int unsigned DEFAULT_WIDTH = 128;

  // Buffer occupancy: EMPTY (0), HALF (main live), FULL (main and skid live).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage : pipe_stage_buffer_pkg

// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
// Two-entry skid buffer between pipeline stages. The main register drives
// out_data; the skid register absorbs the payload accepted while the
// downstream stage stalls, so in_ready can come straight from a flop with no
// combinational path from out_ready.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   upstream presents a payload
//   in_ready   buffer accepts a payload this cycle (registered)
//   in_data    upstream payload
//   flush      discard all held payloads
//   out_valid  out_data holds a live payload (registered)
//   out_ready  downstream consumes the payload this cycle
//   out_data   downstream payload (registered)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  buf_state_e       state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic in_xfer_s;
  logic out_xfer_s;
  logic stall_s;

  // Handshakes are qualified only by registered readiness/validity.
  assign in_xfer_s  = in_valid & in_ready_q;
  assign out_xfer_s = out_valid_q & out_ready;
  assign stall_s    = out_valid_q & ~out_ready;

  // Occupancy FSM with payload registers and registered handshake outputs.
  // in_ready/out_valid are loaded with the values implied by the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= {WIDTH{1'b0}};
      skid_q      <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Drop everything; out_data keeps its last value.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer_s) begin
            main_q      <= in_data;
            state_q     <= HALF;
            out_valid_q <= 1'b1;
          end
        end
        HALF: begin
          if (in_xfer_s && out_xfer_s) begin
            main_q <= in_data;
          end else if (in_xfer_s) begin
            skid_q     <= in_data;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (out_xfer_s) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer_s) begin
            main_q     <= skid_q;
            state_q    <= HALF;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall counter next-state; flush does not affect it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

endmodule : pipe_stage_buffer

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buffer
// Directed stimulus with a scoreboard queue of accepted payloads; a monitor
// on the falling edge compares DUT outputs against the queue and a stall
// count model. A second instance with CNT_W=3 shares the stimulus to exercise
// counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

  localparam int unsigned W = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [15:0]  stall_cnt;

  logic         in_ready_s3;
  logic         out_valid_s3;
  logic [W-1:0] out_data_s3;
  logic [2:0]   stall_cnt_s3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];
  int exp_stall    = 0;
  int exp_stall_s3 = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_buffer #(.WIDTH(W), .CNT_W(3)) dut_s3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s3),
    .in_data(in_data), .flush(flush), .out_valid(out_valid_s3),
    .out_ready(out_ready), .out_data(out_data_s3), .stall_cnt(stall_cnt_s3)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare against scoreboard, then advance the model for the coming edge.
  always @(negedge clk) begin
    int sz;
    logic pop_s;
    logic push_s;
    sz = sb_q.size();
    if (reset) begin
      sb_q.delete();
      exp_stall    = 0;
      exp_stall_s3 = 0;
    end else begin
      chk("mon_in_ready", {127'd0, in_ready}, {127'd0, (sz < 2)});
      chk("mon_out_valid", {127'd0, out_valid}, {127'd0, (sz > 0)});
      chk("mon_in_ready_s3", {127'd0, in_ready_s3}, {127'd0, (sz < 2)});
      if (sz > 0) begin
        chk("mon_out_data", out_data, sb_q[0]);
        chk("mon_out_data_s3", out_data_s3, sb_q[0]);
      end
      chk("mon_stall_cnt", {112'd0, stall_cnt}, W'(exp_stall));
      chk("mon_stall_cnt_s3", {125'd0, stall_cnt_s3}, W'(exp_stall_s3));
      if ((sz > 0) && !out_ready) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_stall_s3 < 7) exp_stall_s3++;
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        pop_s  = (sz > 0) && out_ready;
        push_s = in_valid && (sz < 2);
        if (pop_s) void'(sb_q.pop_front());
        if (push_s) sb_q.push_back(in_data);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_stall_cnt", {112'd0, stall_cnt}, 128'd0);

    // Single payload, 1-cycle latency
    step();
    in_valid = 1'b1; in_data = 128'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", {127'd0, out_valid}, 128'd1);
    chk("lat_out_data", out_data, 128'hA5);
    chk("lat_in_ready", {127'd0, in_ready}, 128'd1);
    step(); step();

    // Backpressure: fill to FULL, third payload held upstream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h1;
    step();
    in_data = 128'h2;
    step();
    in_data = 128'h3;
    step(); step();
    @(negedge clk);
    chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    chk("bp_out_data", out_data, 128'h1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_0", out_data, 128'h1);
    step();
    @(negedge clk);
    chk("drain_1", out_data, 128'h2);
    chk("drain_1_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_2", out_data, 128'h3);
    chk("drain_2_valid", {127'd0, out_valid}, 128'd1);
    step();
    @(negedge clk);
    chk("drain_empty", {127'd0, out_valid}, 128'd0);

    // Stall counter and saturation, from a fresh reset
    step();
    reset = 1'b1; out_ready = 1'b0;
    step(); step();
    reset = 1'b0; in_valid = 1'b1; in_data = 128'h11;
    step();
    in_data = 128'h22;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("stall_5", {112'd0, stall_cnt}, 128'd5);
    chk("stall_5_s3", {125'd0, stall_cnt_s3}, 128'd5);
    repeat (5) step();
    @(negedge clk);
    chk("stall_10", {112'd0, stall_cnt}, 128'd10);
    chk("stall_sat_s3", {125'd0, stall_cnt_s3}, 128'd7);

    // Flush in FULL with a payload offered
    step();
    flush = 1'b1; in_valid = 1'b1; in_data = 128'h9;
    @(negedge clk);
    chk("flush_pre_in_ready", {127'd0, in_ready}, 128'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
    chk("flush_out_data_kept", out_data, 128'h11);
    chk("flush_stall_kept", {112'd0, stall_cnt}, 128'd12);
    step();
    out_ready = 1'b1;
    repeat (3) step();

    // Streaming: simultaneous in and out for 100 cycles
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = W'(256 + i);
      @(negedge clk);
      chk("stream_in_ready", {127'd0, in_ready}, 128'd1);
      if (i > 0) begin
        chk("stream_out_data", out_data, W'(256 + i - 1));
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", out_data, W'(256 + 99));
    step(); step();

    // Reset in FULL together with flush and in_valid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h55;
    step();
    in_data = 128'h66;
    step(); step();
    reset = 1'b1; flush = 1'b1; in_data = 128'h77;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rstfull_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rstfull_out_data", out_data, 128'd0);
    chk("rstfull_stall", {112'd0, stall_cnt}, 128'd0);
    chk("rstfull_in_ready", {127'd0, in_ready}, 128'd1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_buffer
